game_timer_ctrl: RTL and testbench

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

---
 rtl/game_timer_ctrl.sv | 153 +++++++++++++++
 tb/tb_game_timer_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/game_timer_ctrl.sv
// Game countdown timer: BCD m:ss display value, one-second prescaler, wrong-entry penalty.
// Freeze/expire/idle sequencing follows the game controller's state code.
module game_timer_ctrl #(
  parameter int          TICKS_PER_SEC = 50000000,
  parameter logic [11:0] START_TIME    = 12'h300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_current,
  input  logic        penalty,
  output logic [11:0] cur_time,
  output logic        running,
  output logic        sec_pulse,
  output logic        expired
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN, S_EXPIRED} state_t;

  state_t          r_state, w_state;
  logic [PW-1:0]   r_presc, w_presc;
  logic [11:0]     r_time, w_time;
  logic            r_running, w_running;
  logic            r_sec_pulse, w_sec_pulse;
  logic            r_expired, w_expired;

  logic            w_tick;
  logic            w_freeze;
  logic            w_release;
  logic [3:0]      w_ded;
  logic [11:0]     w_dec_time;

  function automatic logic [11:0] bcd_dec1(input logic [11:0] t);
    logic [11:0] r;
    r = t;
    if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) r[7:4] = t[7:4] - 4'd1;
      else begin
        r[7:4]  = 4'd5;
        r[11:8] = t[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] bcd_dec10(input logic [11:0] t);
    logic [11:0] r;
    r = t;
    if (t[7:4] != 4'd0) r[7:4] = t[7:4] - 4'd1;
    else begin
      r[7:4]  = 4'd5;
      r[11:8] = t[11:8] - 4'd1;
    end
    return r;
  endfunction

  function automatic logic [9:0] bcd_secs(input logic [11:0] t);
    return 10'(t[11:8]) * 10'd60 + 10'(t[7:4]) * 10'd10 + 10'(t[3:0]);
  endfunction

  assign w_tick    = (r_presc == PW'(TICKS_PER_SEC - 1));
  assign w_freeze  = (s_current == 8'h20) || (s_current == 8'h30);
  assign w_release = (s_current == 8'h21) || (s_current == 8'h31) || (s_current == 8'h00);

  always_comb begin
    w_ded = 4'd0;
    if (w_tick && penalty) w_ded = 4'd11;
    else if (penalty)      w_ded = 4'd10;
    else if (w_tick)       w_ded = 4'd1;
  end

  // Saturate whenever the deduction would reach or pass zero; otherwise borrow digit-wise.
  always_comb begin
    w_dec_time = r_time;
    if (w_ded != 4'd0) begin
      if (bcd_secs(r_time) <= 10'(w_ded)) w_dec_time = 12'h000;
      else if (w_ded == 4'd11)            w_dec_time = bcd_dec10(bcd_dec1(r_time));
      else if (w_ded == 4'd10)            w_dec_time = bcd_dec10(r_time);
      else                                w_dec_time = bcd_dec1(r_time);
    end
  end

  always_comb begin
    w_state     = r_state;
    w_presc     = '0;
    w_time      = r_time;
    w_running   = 1'b0;
    w_sec_pulse = 1'b0;
    w_expired   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_time = START_TIME;
        if (s_current == 8'h01) begin
          w_state   = S_RUN;
          w_running = 1'b1;
        end
      end
      S_RUN: begin
        if (w_freeze) begin
          w_state = S_FROZEN;
        end else begin
          w_presc     = w_tick ? '0 : r_presc + PW'(1);
          w_time      = w_dec_time;
          w_sec_pulse = w_tick;
          w_running   = 1'b1;
          if ((w_ded != 4'd0) && (w_dec_time == 12'h000)) begin
            w_state   = S_EXPIRED;
            w_expired = 1'b1;
            w_running = 1'b0;
            w_presc   = '0;
          end
        end
      end
      S_FROZEN, S_EXPIRED: begin
        if (w_release) begin
          w_state = S_IDLE;
          w_time  = START_TIME;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_time  = START_TIME;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_time      <= START_TIME;
      r_running   <= 1'b0;
      r_sec_pulse <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_presc     <= w_presc;
      r_time      <= w_time;
      r_running   <= w_running;
      r_sec_pulse <= w_sec_pulse;
      r_expired   <= w_expired;
    end
  end

  assign cur_time  = r_time;
  assign running   = r_running;
  assign sec_pulse = r_sec_pulse;
  assign expired   = r_expired;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl (4 ticks/s); pulse events are scoreboarded via queues.
module tb_game_timer_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  s_current, s2, s3;
  logic        penalty, p2, p3;
  logic [11:0] cur_time, t2, t3;
  logic        running, sec_pulse, expired;
  logic        run2, sp2, ex2, run3, sp3, ex3;

  int total = 0;
  int bad   = 0;
  bit mon_en = 0;
  logic [11:0] sec_q[$];
  logic [11:0] exp_q[$];

  game_timer_ctrl #(.TICKS_PER_SEC(4), .START_TIME(12'h012)) dut (
    .clk(clk), .rst(rst), .s_current(s_current), .penalty(penalty),
    .cur_time(cur_time), .running(running), .sec_pulse(sec_pulse), .expired(expired));

  game_timer_ctrl #(.TICKS_PER_SEC(4), .START_TIME(12'h100)) dut2 (
    .clk(clk), .rst(rst), .s_current(s2), .penalty(p2),
    .cur_time(t2), .running(run2), .sec_pulse(sp2), .expired(ex2));

  game_timer_ctrl #(.TICKS_PER_SEC(4), .START_TIME(12'h105)) dut3 (
    .clk(clk), .rst(rst), .s_current(s3), .penalty(p3),
    .cur_time(t3), .running(run3), .sec_pulse(sp3), .expired(ex3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every sec_pulse / expired pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sec_pulse) begin
        if (sec_q.size() == 0) chk("sec_pulse_unexpected", 12'd1, 12'd0);
        else chk("sec_pulse_time", cur_time, sec_q.pop_front());
      end
      if (expired) begin
        if (exp_q.size() == 0) chk("expired_unexpected", 12'd1, 12'd0);
        else chk("expired_time", cur_time, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; s_current = 8'h00; penalty = 1'b0;
    s2 = 8'h00; p2 = 1'b0; s3 = 8'h00; p3 = 1'b0;
    cyc(3);
    chk("rst_time", cur_time, 12'h012);
    chk("rst_running", 12'(running), 12'd0);
    chk("rst_sec_pulse", 12'(sec_pulse), 12'd0);
    chk("rst_expired", 12'(expired), 12'd0);
    chk("rst_time2", t2, 12'h100);
    rst = 1'b1; mon_en = 1'b1;
    cyc(2);
    chk("idle_00", cur_time, 12'h012);
    s_current = 8'h02; cyc(2);
    chk("idle_02_running", 12'(running), 12'd0);

    // basic countdown through to expiry
    s_current = 8'h01;
    sec_q.push_back(12'h011); sec_q.push_back(12'h010); sec_q.push_back(12'h009);
    cyc(1);
    chk("run_entry_running", 12'(running), 12'd1);
    chk("run_entry_time", cur_time, 12'h012);
    cyc(3);
    chk("pre_tick_time", cur_time, 12'h012);
    chk("pre_tick_pulse", 12'(sec_pulse), 12'd0);
    cyc(1);
    chk("tick1_time", cur_time, 12'h011);
    chk("tick1_pulse", 12'(sec_pulse), 12'd1);
    s_current = 8'h10;
    cyc(4);
    chk("tick2_time", cur_time, 12'h010);
    s_current = 8'h01;
    cyc(4);
    chk("tick3_time", cur_time, 12'h009);
    for (int k = 8; k >= 0; k--) sec_q.push_back(12'(k));
    exp_q.push_back(12'h000);
    cyc(35);
    chk("cyc47_time", cur_time, 12'h001);
    chk("cyc47_running", 12'(running), 12'd1);
    cyc(1);
    chk("cyc48_time", cur_time, 12'h000);
    chk("cyc48_expired", 12'(expired), 12'd1);
    chk("cyc48_running", 12'(running), 12'd0);
    cyc(1);
    chk("expired_one_cycle", 12'(expired), 12'd0);
    penalty = 1'b1; cyc(1); penalty = 1'b0;
    cyc(8);
    chk("expired_hold", cur_time, 12'h000);
    s_current = 8'h31; cyc(1);
    chk("expired_to_idle", cur_time, 12'h012);
    chk("idle_running", 12'(running), 12'd0);
    s_current = 8'h00; penalty = 1'b1; cyc(1); penalty = 1'b0;
    chk("idle_penalty_ignored", cur_time, 12'h012);

    // penalty saturation
    s_current = 8'h01; cyc(1);
    penalty = 1'b1; cyc(1); penalty = 1'b0;
    chk("pen1_time", cur_time, 12'h002);
    chk("pen1_running", 12'(running), 12'd1);
    exp_q.push_back(12'h000);
    penalty = 1'b1; cyc(1); penalty = 1'b0;
    chk("pen2_time", cur_time, 12'h000);
    chk("pen2_expired", 12'(expired), 12'd1);
    s_current = 8'h21; cyc(1);
    chk("pen_to_idle", cur_time, 12'h012);
    s_current = 8'h00; cyc(1);

    // tick + penalty together, then freeze on a tick cycle
    s_current = 8'h01; cyc(1);
    cyc(3);
    penalty = 1'b1; sec_q.push_back(12'h001); cyc(1); penalty = 1'b0;
    chk("tick_pen_time", cur_time, 12'h001);
    chk("tick_pen_pulse", 12'(sec_pulse), 12'd1);
    cyc(3);
    s_current = 8'h20; cyc(1);
    chk("freeze_time", cur_time, 12'h001);
    chk("freeze_running", 12'(running), 12'd0);
    chk("freeze_pulse", 12'(sec_pulse), 12'd0);
    penalty = 1'b1; cyc(1); penalty = 1'b0;
    cyc(4);
    chk("frozen_hold", cur_time, 12'h001);
    s_current = 8'h00; cyc(1);
    chk("frozen_to_idle", cur_time, 12'h012);

    // reset mid-run at 007
    s_current = 8'h01; cyc(1);
    for (int k = 1; k <= 5; k++) sec_q.push_back(12'h012 - 12'(k) - ((k > 2) ? 12'h006 : 12'h000));
    cyc(20);
    chk("pre_reset_time", cur_time, 12'h007);
    rst = 1'b0; s_current = 8'h00; cyc(1);
    chk("mid_reset_time", cur_time, 12'h012);
    chk("mid_reset_running", 12'(running), 12'd0);
    chk("mid_reset_expired", 12'(expired), 12'd0);
    rst = 1'b1; cyc(6);
    chk("post_reset_idle", 12'(running), 12'd0);
    s_current = 8'h01; cyc(1);
    cyc(3);
    chk("post_reset_pre_tick", cur_time, 12'h012);
    sec_q.push_back(12'h011);
    cyc(1);
    chk("post_reset_tick", cur_time, 12'h011);
    s_current = 8'h30; cyc(1);
    s_current = 8'h00; cyc(1);
    chk("idle_again", cur_time, 12'h012);

    // minute borrow cases
    s2 = 8'h01; s3 = 8'h01; cyc(1);
    chk("b2_entry", t2, 12'h100);
    chk("b3_entry", t3, 12'h105);
    p3 = 1'b1; cyc(1); p3 = 1'b0;
    chk("b3_pen_borrow", t3, 12'h055);
    cyc(3);
    chk("b2_tick_borrow", t2, 12'h059);
    chk("b2_tick_pulse", 12'(sp2), 12'd1);
    chk("b3_tick", t3, 12'h054);

    cyc(2);
    chk("sec_q_drained", 12'(sec_q.size()), 12'd0);
    chk("exp_q_drained", 12'(exp_q.size()), 12'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
